// File: rtl/ofdm_cp_inserter.sv
// Transmit OFDM burst framer: ping-pong symbol buffer, cyclic-prefix insertion, burst sequencing.
// Optional trailing zero guard interval enabled by defining GUARD_ZERO_EN.
module ofdm_cp_inserter #(
  parameter int FFT_POINT      = 64,
  parameter int CP_NUM         = 16,
  parameter int PREAMB_SYM_NUM = 6,
  parameter int SYM_NUM        = 8,
  parameter int GUARD_NUM      = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] din,
  input  logic       wren,
  output logic       in_ready,
  output logic [7:0] dout,
  output logic       dout_valid,
  input  logic       dout_ready,
  output logic       sof,
  output logic       tx_done,
  output logic       underrun
);

  localparam int AW   = $clog2(FFT_POINT);
  localparam int SYMS = PREAMB_SYM_NUM + SYM_NUM;
  localparam int SW   = (SYMS > 1) ? $clog2(SYMS) : 1;
  localparam int GW   = (GUARD_NUM > 1) ? $clog2(GUARD_NUM) : 1;

  localparam logic [AW-1:0] CP_START   = AW'(FFT_POINT - CP_NUM);
  localparam logic [AW-1:0] IDX_LAST   = AW'(FFT_POINT - 1);
  localparam logic [SW-1:0] SYM_LAST   = SW'(SYMS - 1);
  localparam logic [GW-1:0] GUARD_LAST = GW'(GUARD_NUM - 1);

`ifdef GUARD_ZERO_EN
  localparam bit GUARD_EN = 1'b1;
`else
  localparam bit GUARD_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, CP, BODY, GUARD} state_t;

  state_t state, state_next;

  logic [7:0]    mem [2*FFT_POINT];
  logic [1:0]    bank_full;
  logic          wr_bank;
  logic [AW-1:0] wr_cnt;
  logic          wr_fire;
  logic [1:0]    set_mask, clr_mask;

  logic          rd_bank, rd_bank_next;
  logic [AW-1:0] rd_idx, rd_idx_next, fetch_idx;
  logic [SW-1:0] sym_cnt, sym_cnt_next;
  logic [GW-1:0] guard_cnt, guard_cnt_next;
  logic          last_sample;
  logic          advance;
  logic          load, load_zero, load_sof, load_last, clr_full, starve;

  assign in_ready = !bank_full[wr_bank];
  assign wr_fire  = wren && in_ready;
  assign advance  = !dout_valid || dout_ready;

  assign set_mask = (wr_fire && wr_cnt == IDX_LAST) ? (2'b01 << wr_bank) : 2'b00;
  assign clr_mask = clr_full ? (2'b01 << rd_bank) : 2'b00;

  always_ff @(posedge clk) begin
    if (wr_fire) mem[{wr_bank, wr_cnt}] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_bank   <= 1'b0;
      wr_cnt    <= '0;
      bank_full <= 2'b00;
    end else begin
      if (wr_fire) begin
        wr_cnt <= wr_cnt + 1'b1;
        if (wr_cnt == IDX_LAST) wr_bank <= ~wr_bank;
      end
      // write-set and read-clear always hit different banks, so both apply
      bank_full <= (bank_full | set_mask) & ~clr_mask;
    end
  end

  // IDLE fetches the first CP sample directly so the burst starts one cycle after the bank fills
  assign fetch_idx = (state == IDLE) ? CP_START : rd_idx;

  always_comb begin
    state_next     = state;
    rd_idx_next    = rd_idx;
    rd_bank_next   = rd_bank;
    sym_cnt_next   = sym_cnt;
    guard_cnt_next = guard_cnt;
    load           = 1'b0;
    load_zero      = 1'b0;
    load_sof       = 1'b0;
    load_last      = 1'b0;
    clr_full       = 1'b0;
    starve         = 1'b0;
    if (advance) begin
      case (state)
        IDLE, CP: begin
          if (bank_full[rd_bank]) begin
            load     = 1'b1;
            load_sof = (fetch_idx == CP_START) && (sym_cnt == '0);
            if (fetch_idx == IDX_LAST) begin
              state_next  = BODY;
              rd_idx_next = '0;
            end else begin
              state_next  = CP;
              rd_idx_next = fetch_idx + 1'b1;
            end
          end else begin
            starve = (sym_cnt != '0);
          end
        end
        BODY: begin
          load = 1'b1;
          if (rd_idx == IDX_LAST) begin
            clr_full     = 1'b1;
            rd_bank_next = ~rd_bank;
            if (sym_cnt == SYM_LAST) begin
              sym_cnt_next = '0;
              load_last    = !GUARD_EN;
              if (GUARD_EN) begin
                state_next     = GUARD;
                guard_cnt_next = '0;
              end else begin
                state_next = IDLE;
              end
            end else begin
              sym_cnt_next = sym_cnt + 1'b1;
              state_next   = CP;
              rd_idx_next  = CP_START;
            end
          end else begin
            rd_idx_next = rd_idx + 1'b1;
          end
        end
        GUARD: begin
          load      = 1'b1;
          load_zero = 1'b1;
          if (guard_cnt == GUARD_LAST) begin
            state_next = IDLE;
            load_last  = 1'b1;
          end else begin
            guard_cnt_next = guard_cnt + 1'b1;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      rd_idx      <= '0;
      rd_bank     <= 1'b0;
      sym_cnt     <= '0;
      guard_cnt   <= '0;
      dout        <= 8'h00;
      dout_valid  <= 1'b0;
      sof         <= 1'b0;
      last_sample <= 1'b0;
      tx_done     <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      state     <= state_next;
      rd_idx    <= rd_idx_next;
      rd_bank   <= rd_bank_next;
      sym_cnt   <= sym_cnt_next;
      guard_cnt <= guard_cnt_next;
      tx_done   <= dout_valid && dout_ready && last_sample;
      if (advance) begin
        if (load) begin
          dout        <= load_zero ? 8'h00 : mem[{rd_bank, fetch_idx}];
          dout_valid  <= 1'b1;
          sof         <= load_sof;
          last_sample <= load_last;
        end else begin
          dout_valid  <= 1'b0;
          sof         <= 1'b0;
          last_sample <= 1'b0;
        end
      end
      if (load && load_sof) underrun <= 1'b0;
      else if (starve)      underrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ofdm_cp_inserter.sv
// Scoreboard bench for ofdm_cp_inserter: writer pushes expected burst samples, negedge monitor checks them.
module tb_ofdm_cp_inserter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] din = 8'h00;
  logic       wren = 1'b0;
  logic       in_ready;
  logic [7:0] dout;
  logic       dout_valid;
  logic       dout_ready = 1'b1;
  logic       sof;
  logic       tx_done;
  logic       underrun;

`ifdef GUARD_ZERO_EN
  localparam int GUARD_LEN = 32;
`else
  localparam int GUARD_LEN = 0;
`endif

  typedef struct {
    logic [7:0] data;
    logic       sof;
    logic       last;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   fails = 0;
  int   acc_cnt = 0;
  bit   rand_mode = 1'b0;
  logic ready_level = 1'b1;
  bit   abort = 1'b0;

  logic       pend_tx = 1'b0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_dout = 8'h00;
  logic       prev_sof = 1'b0;

  ofdm_cp_inserter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .wren       (wren),
    .in_ready   (in_ready),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .sof        (sof),
    .tx_done    (tx_done),
    .underrun   (underrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    dout_ready = rand_mode ? 1'($urandom_range(0, 1)) : ready_level;
  end

  function automatic logic [7:0] val(int b, int s, int i);
    return 8'(b * 11 + s * 37 + i * 3);
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    vectors++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic push_sym(int b, int s);
    exp_t e;
    for (int k = 0; k < 80; k++) begin
      e.data = val(b, s, (k < 16) ? 48 + k : k - 16);
      e.sof  = (s == 0 && k == 0);
      e.last = (s == 13 && k == 79 && GUARD_LEN == 0);
      exp_q.push_back(e);
    end
    if (s == 13) begin
      for (int g = 0; g < GUARD_LEN; g++) begin
        e.data = 8'h00;
        e.sof  = 1'b0;
        e.last = (g == GUARD_LEN - 1);
        exp_q.push_back(e);
      end
    end
  endtask

  // called aligned to posedge+1; returns aligned to posedge+1 of the last accept
  task automatic write_sym(int b, int s);
    logic ok;
    int   budget;
    push_sym(b, s);
    for (int i = 0; i < 64; i++) begin
      if (abort) break;
      din    = val(b, s, i);
      wren   = 1'b1;
      budget = 0;
      forever begin
        @(negedge clk);
        ok = in_ready;
        @(posedge clk);
        #1;
        if (ok || abort) break;
        budget++;
        if (budget > 5000) begin
          vectors++;
          fails++;
          $display("FAIL in_ready_timeout: burst %0d sym %0d idx %0d never accepted", b, s, i);
          break;
        end
      end
    end
    wren = 1'b0;
  endtask

  task automatic wait_drain();
    int t;
    for (t = 0; t < 30000; t++) begin
      @(negedge clk);
      if (exp_q.size() == 0) break;
    end
    if (exp_q.size() != 0) begin
      vectors++;
      fails++;
      $display("FAIL drain_timeout: got %0d samples pending, expected 0", exp_q.size());
      exp_q.delete();
    end
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(string tag);
    @(negedge clk);
    check({tag, "_dout"}, 32'(dout), 0);
    check({tag, "_dout_valid"}, 32'(dout_valid), 0);
    check({tag, "_sof"}, 32'(sof), 0);
    check({tag, "_tx_done"}, 32'(tx_done), 0);
    check({tag, "_underrun"}, 32'(underrun), 0);
    check({tag, "_in_ready"}, 32'(in_ready), 1);
  endtask

  // monitor: pops one expected sample per accepted output
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      pend_tx    = 1'b0;
      prev_stall = 1'b0;
    end else begin
      if (tx_done || pend_tx) check("tx_done", 32'(tx_done), 32'(pend_tx));
      pend_tx = 1'b0;
      if (prev_stall) begin
        check("hold_dout", 32'(dout), 32'(prev_dout));
        check("hold_sof", 32'(sof), 32'(prev_sof));
        check("hold_valid", 32'(dout_valid), 1);
      end
      if (dout_valid && dout_ready) begin
        if (exp_q.size() == 0) begin
          vectors++;
          fails++;
          $display("FAIL unexpected_sample: got %0h, expected no output", dout);
        end else begin
          e = exp_q.pop_front();
          check("dout", 32'(dout), 32'(e.data));
          check("sof", 32'(sof), 32'(e.sof));
          if (e.sof) check("underrun_at_sof", 32'(underrun), 0);
          pend_tx = e.last;
          acc_cnt++;
        end
      end
      prev_stall = dout_valid && !dout_ready;
      prev_dout  = dout;
      prev_sof   = sof;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // reset values
    rst_n = 1'b0;
    check_reset_vals("in_reset");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_reset_vals("after_reset");
    @(posedge clk);
    #1;

    // burst 0: full rate, plus first-symbol latency
    write_sym(0, 0);
    @(negedge clk);
    check("lat_edge_n_valid", 32'(dout_valid), 0);
    @(negedge clk);
    check("lat_edge_n1_valid", 32'(dout_valid), 1);
    check("lat_edge_n1_dout", 32'(dout), 32'(val(0, 0, 48)));
    @(posedge clk);
    #1;
    for (int s = 1; s < 14; s++) write_sym(0, s);
    wait_drain();

    // burst 1: backpressure, both banks full
    ready_level = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    write_sym(1, 0);
    write_sym(1, 1);
    @(negedge clk);
    check("both_full_in_ready", 32'(in_ready), 0);
    check("stalled_valid", 32'(dout_valid), 1);
    @(posedge clk);
    #1;
    rand_mode = 1'b1;
    for (int s = 2; s < 14; s++) write_sym(1, s);
    wait_drain();
    rand_mode   = 1'b0;
    ready_level = 1'b1;
    repeat (2) begin @(posedge clk); #1; end

    // burst 2: input starves after symbol 3
    for (int s = 0; s < 4; s++) write_sym(2, s);
    repeat (200) @(posedge clk);
    @(negedge clk);
    check("starved_underrun", 32'(underrun), 1);
    check("starved_valid", 32'(dout_valid), 0);
    @(posedge clk);
    #1;
    for (int s = 4; s < 14; s++) write_sym(2, s);
    wait_drain();
    @(negedge clk);
    check("underrun_sticky", 32'(underrun), 1);
    @(posedge clk);
    #1;

    // burst 3: reset after 500 accepted samples
    acc_cnt = 0;
    abort   = 1'b0;
    fork
      begin
        for (int s = 0; s < 14; s++) if (!abort) write_sym(3, s);
      end
      begin
        int t;
        t = 0;
        while (acc_cnt < 500 && t < 20000) begin
          @(posedge clk);
          t++;
        end
        if (acc_cnt < 500) begin
          vectors++;
          fails++;
          $display("FAIL reset_trigger_timeout: got %0d samples, expected 500", acc_cnt);
        end
        #1;
        rst_n = 1'b0;
        abort = 1'b1;
      end
    join
    exp_q.delete();
    check_reset_vals("mid_burst_reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    abort = 1'b0;
    @(posedge clk);
    #1;

    // burst 4: clean burst after reset
    for (int s = 0; s < 14; s++) write_sym(4, s);
    wait_drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
